// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush controls
// and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_busy;
  logic             halt_req;
  logic             resume;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_mem_read, ex_rd, branch_taken,
    output imem_ready, dmem_busy, halt_req, resume,
    input  pc_write, if_id_write, if_id_flush,
    input  id_ex_write, id_ex_flush, halted,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_mem_read, ex_rd, branch_taken,
    input  imem_ready, dmem_busy, halt_req, resume,
    output pc_write, if_id_write, if_id_flush,
    output id_ex_write, id_ex_flush, halted,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, redirects,
// fetch waits, D-mem freeze, halt; saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_STALL = 2,
  parameter int CNT_W          = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int DN_W =
    (LOAD_USE_STALL > 2) ? $clog2(LOAD_USE_STALL - 1) : 1;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [DN_W-1:0]  dn_q, dn_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, hlt;
  logic lu, rs1_hit, rs2_hit, redirect;

  assign rs1_hit = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
  assign rs2_hit = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
  assign lu = hz.ex_mem_read && (hz.ex_rd != 5'd0)
           && (rs1_hit || rs2_hit);

  always_comb begin
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    ifid_f   = 1'b0;
    idex_w   = 1'b1;
    idex_f   = 1'b0;
    hlt      = 1'b0;
    redirect = 1'b0;
    state_d  = state_q;
    dn_d     = dn_q;
    if (rst) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      ifid_f  = 1'b1;
      idex_w  = 1'b0;
      idex_f  = 1'b1;
      state_d = RUN;
      dn_d    = '0;
    end else if (hz.dmem_busy) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_w = 1'b0;
    end else if (hz.branch_taken) begin
      ifid_f   = 1'b1;
      idex_f   = 1'b1;
      redirect = 1'b1;
      state_d  = RUN;
      dn_d     = '0;
    end else if (state_q == HALTED) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      ifid_f = 1'b1;
      hlt    = 1'b1;
      if (hz.resume) state_d = RUN;
    end else if (state_q == RUN && hz.halt_req) begin
      // halt insn moves on to EX; its successor is refetched on resume
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      ifid_f  = 1'b1;
      state_d = HALTED;
    end else if (state_q == LOAD_STALL || lu) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_f = 1'b1;
      if (state_q == RUN) begin
        if (LOAD_USE_STALL > 1) begin
          state_d = LOAD_STALL;
          dn_d    = DN_W'(LOAD_USE_STALL - 2);
        end
      end else if (dn_q == '0) begin
        state_d = RUN;
      end else begin
        dn_d = dn_q - 1'b1;
      end
    end else if (!hz.imem_ready) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      ifid_f = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_w && stall_q != '1) stall_d = stall_q + 1'b1;
    if (redirect && flush_q != '1) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      dn_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      dn_q    <= dn_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.pc_write    = pc_w;
  assign hz.if_id_write = ifid_w;
  assign hz.if_id_flush = ifid_f;
  assign hz.id_ex_write = idex_w;
  assign hz.id_ex_flush = idex_f;
  assign hz.halted      = hlt;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stall, flush, freeze,
// halt and reset sequences with hand-computed controls and counts.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();

  pipeline_hazard_ctrl #(
    .LOAD_USE_STALL(2),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, halted}
  localparam logic [5:0] C_NRM = 6'b110100;
  localparam logic [5:0] C_RST = 6'b001010;
  localparam logic [5:0] C_LU  = 6'b000110;
  localparam logic [5:0] C_BR  = 6'b111110;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_HLT = 6'b001101;
  localparam logic [5:0] C_HRQ = 6'b001100;
  localparam logic [5:0] C_IMW = 6'b001100;

  logic [5:0] ctl;
  assign ctl = {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                hz.id_ex_write, hz.id_ex_flush, hz.halted};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f);
    chk({tag, ".stall"}, hz.stall_cnt, 32'(s));
    chk({tag, ".flush"}, hz.flush_cnt, 32'(f));
  endtask

  task automatic set_lu(input logic on, input logic [4:0] rd);
    hz.ex_mem_read = on;
    hz.ex_rd       = rd;
    hz.id_rs1      = 5'd5;
    hz.id_use_rs1  = on;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst             = 1'b1;
    hz.id_rs1       = '0;
    hz.id_rs2       = '0;
    hz.id_use_rs1   = 1'b0;
    hz.id_use_rs2   = 1'b0;
    hz.ex_mem_read  = 1'b0;
    hz.ex_rd        = '0;
    hz.branch_taken = 1'b0;
    hz.imem_ready   = 1'b1;
    hz.dmem_busy    = 1'b0;
    hz.halt_req     = 1'b0;
    hz.resume       = 1'b0;

    // T1 reset
    #1;
    chk("t1.rst0", 32'(ctl), 32'(C_RST));
    tick();
    chk("t1.rst1", 32'(ctl), 32'(C_RST));
    tick();
    rst = 1'b0;
    #1;
    chk("t1.idle", 32'(ctl), 32'(C_NRM));
    chk_cnt("t1", 0, 0);
    tick();
    chk("t1.idle2", 32'(ctl), 32'(C_NRM));

    // T2 load-use, two bubbles
    set_lu(1'b1, 5'd5);
    #1;
    chk("t2.lu0", 32'(ctl), 32'(C_LU));
    tick();
    set_lu(1'b0, 5'd0);
    #1;
    chk("t2.lu1", 32'(ctl), 32'(C_LU));
    tick();
    chk("t2.run", 32'(ctl), 32'(C_NRM));
    chk_cnt("t2", 2, 0);
    // x0 destination never stalls
    hz.ex_mem_read = 1'b1;
    hz.ex_rd       = 5'd0;
    hz.id_rs1      = 5'd0;
    hz.id_use_rs1  = 1'b1;
    #1;
    chk("t2.x0", 32'(ctl), 32'(C_NRM));
    tick();
    chk_cnt("t2.x0", 2, 0);
    // rs2 match stalls as well
    hz.id_use_rs1 = 1'b0;
    hz.ex_rd      = 5'd9;
    hz.id_rs2     = 5'd9;
    hz.id_use_rs2 = 1'b1;
    #1;
    chk("t2.rs2", 32'(ctl), 32'(C_LU));
    tick();
    hz.ex_mem_read = 1'b0;
    hz.id_use_rs2  = 1'b0;
    tick();
    chk_cnt("t2.rs2", 4, 0);

    // T3 branch beats load-use
    set_lu(1'b1, 5'd5);
    hz.branch_taken = 1'b1;
    #1;
    chk("t3.br", 32'(ctl), 32'(C_BR));
    tick();
    set_lu(1'b0, 5'd0);
    hz.branch_taken = 1'b0;
    #1;
    chk("t3.run", 32'(ctl), 32'(C_NRM));
    chk_cnt("t3", 4, 1);

    // T4 freeze in first LOAD_STALL cycle
    set_lu(1'b1, 5'd5);
    #1;
    chk("t4.lu", 32'(ctl), 32'(C_LU));
    tick();
    set_lu(1'b0, 5'd0);
    hz.dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4.frz", 32'(ctl), 32'(C_FRZ));
      tick();
    end
    hz.dmem_busy = 1'b0;
    #1;
    chk("t4.ls", 32'(ctl), 32'(C_LU));
    tick();
    chk("t4.run", 32'(ctl), 32'(C_NRM));
    chk_cnt("t4", 9, 1);

    // T5 halt for 10 cycles
    hz.halt_req = 1'b1;
    #1;
    chk("t5.req", 32'(ctl), 32'(C_HRQ));
    tick();
    hz.halt_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("t5.hlt", 32'(ctl), 32'(C_HLT));
      tick();
    end
    hz.resume = 1'b1;
    #1;
    chk("t5.res", 32'(ctl), 32'(C_HLT));
    tick();
    hz.resume = 1'b0;
    #1;
    chk("t5.run", 32'(ctl), 32'(C_NRM));
    chk_cnt("t5", 20, 1);

    // T6 fetch wait
    hz.imem_ready = 1'b0;
    #1;
    chk("t6.im0", 32'(ctl), 32'(C_IMW));
    tick();
    chk("t6.im1", 32'(ctl), 32'(C_IMW));
    tick();
    hz.imem_ready = 1'b1;
    #1;
    chk("t6.run", 32'(ctl), 32'(C_NRM));
    chk_cnt("t6", 22, 1);

    // branch aborts halt
    hz.halt_req = 1'b1;
    tick();
    hz.halt_req     = 1'b0;
    hz.branch_taken = 1'b1;
    #1;
    chk("t6.hbr", 32'(ctl), 32'(C_BR));
    tick();
    hz.branch_taken = 1'b0;
    #1;
    chk("t6.hrun", 32'(ctl), 32'(C_NRM));
    chk_cnt("t6.h", 23, 2);

    // reset during LOAD_STALL
    set_lu(1'b1, 5'd5);
    tick();
    set_lu(1'b0, 5'd0);
    rst = 1'b1;
    #1;
    chk("t6.rst", 32'(ctl), 32'(C_RST));
    tick();
    rst = 1'b0;
    #1;
    chk("t6.rrun", 32'(ctl), 32'(C_NRM));
    chk_cnt("t6.r", 0, 0);
    tick();
    chk("t6.rrun2", 32'(ctl), 32'(C_NRM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
